// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pll_lock_sequencer
// Brief  : iCE40 PLL reset/bypass/lock sequencer in the crystal domain. The
//          optional RUN-state lock-loss glitch filter is enabled by the
//          PLL_LOCK_GLITCH_FILTER_EN macro.
// Rev    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic       i_xtal,
  input  logic       i_rst_n,
  input  logic       i_pll_lock,
  input  logic       i_resync,
  output logic       o_pll_resetb,
  output logic       o_pll_bypass,
  output logic       o_sys_rst_n,
  output logic       o_ready,
  output logic       o_fail,
  output logic [1:0] o_retry_cnt,
  output logic [7:0] o_loss_cnt
);

  localparam int c_max_ab  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int c_cnt_max = (c_max_ab > STABLE_CYCLES) ? c_max_ab : STABLE_CYCLES;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_cnt_w-1:0] c_rst_last     = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK->STABLE edge already consumed one high sample.
  localparam logic [c_cnt_w-1:0] c_stable_last  =
    c_cnt_w'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);

  generate
    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 ||
        MAX_RETRIES < 1 || MAX_RETRIES > 4 || GLITCH_CYCLES < 1) begin : g_bad_params
      $error("pll_lock_sequencer: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAILED     = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_lock_meta;
  logic                 r_lock_s;
  logic                 r_pll_resetb;
  logic                 r_pll_bypass;
  logic                 r_sys_rst_n;
  logic                 r_ready;
  logic                 r_fail;
  logic [1:0]           r_retry_cnt;
  logic [7:0]           r_loss_cnt;
  logic                 w_loss;

  always_ff @(posedge i_xtal or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int c_glitch_w = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam logic [c_glitch_w-1:0] c_glitch_last = c_glitch_w'(GLITCH_CYCLES - 1);

  logic [c_glitch_w-1:0] r_glitch_cnt;

  always_ff @(posedge i_xtal or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_glitch_cnt <= '0;
    end else if (r_state != ST_RUN || r_lock_s) begin
      r_glitch_cnt <= '0;
    end else if (r_glitch_cnt != c_glitch_last) begin
      r_glitch_cnt <= r_glitch_cnt + 1'b1;
    end
  end

  assign w_loss = !r_lock_s && (r_glitch_cnt == c_glitch_last);
`else
  assign w_loss = !r_lock_s;
`endif

  always_ff @(posedge i_xtal or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_RESET_HOLD;
      r_cnt        <= '0;
      r_pll_resetb <= 1'b0;
      r_pll_bypass <= 1'b0;
      r_sys_rst_n  <= 1'b0;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
      r_retry_cnt  <= 2'd0;
      r_loss_cnt   <= 8'd0;
    end else begin
      case (r_state)
        ST_RESET_HOLD: begin
          if (r_cnt == c_rst_last) begin
            r_state      <= ST_WAIT_LOCK;
            r_cnt        <= '0;
            r_pll_resetb <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (r_lock_s) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_timeout_last) begin
            r_cnt        <= '0;
            r_pll_resetb <= 1'b0;
            if (int'(r_retry_cnt) + 1 == MAX_RETRIES) begin
              r_state      <= ST_FAILED;
              r_pll_bypass <= 1'b1;
              r_fail       <= 1'b1;
            end else begin
              r_state     <= ST_RESET_HOLD;
              r_retry_cnt <= r_retry_cnt + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_STABLE: begin
          if (!r_lock_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == c_stable_last) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_sys_rst_n <= 1'b1;
            r_ready     <= 1'b1;
            r_retry_cnt <= 2'd0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          // Loss outranks a simultaneous resync so the event is still counted.
          if (w_loss || i_resync) begin
            r_state      <= ST_RESET_HOLD;
            r_cnt        <= '0;
            r_pll_resetb <= 1'b0;
            r_sys_rst_n  <= 1'b0;
            r_ready      <= 1'b0;
            if (w_loss && r_loss_cnt != 8'hFF) begin
              r_loss_cnt <= r_loss_cnt + 1'b1;
            end
          end
        end

        ST_FAILED: begin
          if (i_resync) begin
            r_state      <= ST_RESET_HOLD;
            r_cnt        <= '0;
            r_pll_bypass <= 1'b0;
            r_fail       <= 1'b0;
            r_sys_rst_n  <= 1'b0;
            r_retry_cnt  <= 2'd0;
          end else if (!r_sys_rst_n) begin
            // Let bypass settle before releasing the system onto the crystal.
            if (r_cnt == c_rst_last) begin
              r_sys_rst_n <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state      <= ST_RESET_HOLD;
          r_cnt        <= '0;
          r_pll_resetb <= 1'b0;
          r_pll_bypass <= 1'b0;
          r_sys_rst_n  <= 1'b0;
          r_ready      <= 1'b0;
          r_fail       <= 1'b0;
        end
      endcase
    end
  end

  assign o_pll_resetb = r_pll_resetb;
  assign o_pll_bypass = r_pll_bypass;
  assign o_sys_rst_n  = r_sys_rst_n;
  assign o_ready      = r_ready;
  assign o_fail       = r_fail;
  assign o_retry_cnt  = r_retry_cnt;
  assign o_loss_cnt   = r_loss_cnt;

endmodule
`default_nettype wire
